// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpu_pkg
// Description : Shared VPU types: functional-unit select, alu/mul mode,
//               element width, fixed-point rounding mode, and the lane
//               sequencer state encoding. Also a helper giving SEW in bits.
// Revision    : 1.0 - initial release
// ============================================================================
package vpu_pkg;

  // Functional unit targeted by an instruction.
  typedef enum logic [1:0] {
    FU_VALU = 2'd0,
    FU_VMUL = 2'd1
  } VPU_FU_t;

  // Opaque alu/mul control word, passed through to the lane.
  typedef logic [4:0] VPU_MODE_t;

  // Selected element width; the encoding is log2(SEW/8).
  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } VSEW_e;

  // Fixed-point rounding mode.
  typedef enum logic [1:0] {
    VXRM_RNU = 2'd0,
    VXRM_RNE = 2'd1,
    VXRM_RDN = 2'd2,
    VXRM_ROD = 2'd3
  } VXRM_e;

  // Lane sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_WB    = 2'd3
  } VPU_SEQ_STATE_e;

  // Element width in bits for a given SEW encoding.
  function automatic int unsigned sew_bits(input VSEW_e sew);
    return 32'd8 << sew;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_elem_select.sv
`default_nettype none
// ============================================================================
// Module      : vpu_elem_select
// Description : Combinational extract of element idx from a VLEN-bit vector
//               at the given SEW, zero-extended to 64 bits.
// Ports       : vec  - source vector register
//               sew  - element width
//               idx  - element index (trusted to be in range for sew)
//               elem - selected element, zero-extended
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_elem_select
  import vpu_pkg::*;
#(
  parameter int VLEN = 256,
  parameter int VL_W = 6
) (
  input  logic [VLEN-1:0] vec,
  input  VSEW_e           sew,
  input  logic [VL_W-1:0] idx,
  output logic [63:0]     elem
);

  // Bit offset is idx * SEW; wide enough for the SEW64 scaling.
  localparam int OFF_W = VL_W + 6;

  logic [OFF_W-1:0] bit_off;
  logic [63:0]      window;

  always_comb begin
    case (sew)
      SEW8:    bit_off = OFF_W'({idx, 3'b000});
      SEW16:   bit_off = OFF_W'({idx, 4'b0000});
      SEW32:   bit_off = OFF_W'({idx, 5'b00000});
      default: bit_off = {idx, 6'b000000};
    endcase
  end

  assign window = 64'(vec >> bit_off);

  always_comb begin
    case (sew)
      SEW8:    elem = {56'd0, window[7:0]};
      SEW16:   elem = {48'd0, window[15:0]};
      SEW32:   elem = {32'd0, window[31:0]};
      default: elem = window;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vpu_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vpu_lane_sequencer
// Description : Issue/collect front end for one VPU lane. Accepts one
//               whole-register vector instruction, issues its elements to
//               the lane one per cycle, collects the in-order result stream
//               into a destination buffer and presents the finished register
//               for VRF writeback.
// Config      : VPU_SEQ_TAIL_AGNOSTIC_EN - when defined, tail elements
//               (index >= vl) are written all-ones; otherwise they keep vs3.
// Ports       : clk_i/rst_i          - clock, synchronous active-high reset
//               req_*                - instruction request (valid/ready)
//               lane_*_o             - per-element issue to the lane
//               lane_result_*_i      - in-order result stream from the lane
//               wb_*                 - destination register writeback
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_lane_sequencer
  import vpu_pkg::*;
#(
  parameter int VLEN     = 256,
  parameter int MAX_ELEM = VLEN / 8,
  parameter int VL_W     = $clog2(MAX_ELEM) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // request
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  VPU_FU_t             req_fu_i,
  input  VPU_MODE_t           req_mode_i,
  input  VSEW_e               req_vsew_i,
  input  VXRM_e               req_vxrm_i,
  input  logic [VL_W-1:0]     req_vl_i,
  input  logic [VLEN-1:0]     req_vs1_i,
  input  logic [VLEN-1:0]     req_vs2_i,
  input  logic [VLEN-1:0]     req_vs3_i,
  input  logic [MAX_ELEM-1:0] req_v0_i,
  // lane issue
  output logic                lane_valid_o,
  output VPU_FU_t             lane_fu_o,
  output VPU_MODE_t           lane_mode_o,
  output VSEW_e               lane_vsew_o,
  output VXRM_e               lane_vxrm_o,
  output logic [63:0]         lane_op1_o,
  output logic [63:0]         lane_op2_o,
  output logic [63:0]         lane_op3_o,
  output logic                lane_mask_o,
  // lane results
  input  logic                lane_result_valid_i,
  input  logic                lane_result_en_i,
  input  logic [63:0]         lane_result_i,
  // writeback
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [VLEN-1:0]     wb_data_o
);

  localparam int IDX_W  = $clog2(MAX_ELEM);
  localparam int NBYTES = VLEN / 8;

  VPU_SEQ_STATE_e        state;
  logic [VL_W-1:0]       vl;
  logic [VL_W-1:0]       issue_idx;
  logic [VL_W-1:0]       retire_idx;
  logic [VL_W-1:0]       retire_nxt;
  logic [VLEN-1:0]       vs1;
  logic [VLEN-1:0]       vs2;
  logic [VLEN-1:0]       vs3;
  logic [MAX_ELEM-1:0]   v0;
  logic [VLEN-1:0]       dest;
  logic [VLEN-1:0]       dest_init;
  logic [VLEN-1:0]       dest_upd;
  VPU_FU_t               fu;
  VPU_MODE_t             mode;
  VSEW_e                 vsew;
  VXRM_e                 vxrm;
  logic                  req_fire;
  logic                  res_accept;
  logic                  all_retired;

  assign req_ready_o = (state == SEQ_IDLE);
  assign req_fire    = req_valid_i && req_ready_o;

  // A result only counts while something is outstanding; anything else
  // (late results after reset, strays in IDLE/WB) is dropped.
  assign res_accept  = lane_result_valid_i &&
                       ((state == SEQ_ISSUE) || (state == SEQ_DRAIN)) &&
                       (retire_idx < vl);
  assign retire_nxt  = retire_idx + VL_W'(res_accept);
  // Includes a result retiring this very cycle, so the last retire and the
  // move to WB happen on the same edge.
  assign all_retired = (retire_nxt == vl);

  // --------------------------------------------------------------------------
  // Request field capture (datapath, no reset needed)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      fu   <= req_fu_i;
      mode <= req_mode_i;
      vsew <= req_vsew_i;
      vxrm <= req_vxrm_i;
      vs1  <= req_vs1_i;
      vs2  <= req_vs2_i;
      vs3  <= req_vs3_i;
      v0   <= req_v0_i;
    end
  end

  assign lane_fu_o   = fu;
  assign lane_mode_o = mode;
  assign lane_vsew_o = vsew;
  assign lane_vxrm_o = vxrm;
  assign lane_mask_o = v0[issue_idx[IDX_W-1:0]];
  assign wb_data_o   = dest;

  // --------------------------------------------------------------------------
  // Operand extraction for the element currently on the lane
  // --------------------------------------------------------------------------
  vpu_elem_select #(.VLEN(VLEN), .VL_W(VL_W)) u_sel_op1 (
    .vec (vs1), .sew (vsew), .idx (issue_idx), .elem (lane_op1_o)
  );
  vpu_elem_select #(.VLEN(VLEN), .VL_W(VL_W)) u_sel_op2 (
    .vec (vs2), .sew (vsew), .idx (issue_idx), .elem (lane_op2_o)
  );
  vpu_elem_select #(.VLEN(VLEN), .VL_W(VL_W)) u_sel_op3 (
    .vec (vs3), .sew (vsew), .idx (issue_idx), .elem (lane_op3_o)
  );

  // --------------------------------------------------------------------------
  // Destination buffer initial value: vs3, with the tail optionally filled
  // --------------------------------------------------------------------------
  always_comb begin
    dest_init = req_vs3_i;
`ifdef VPU_SEQ_TAIL_AGNOSTIC_EN
    // Byte b belongs to element b >> vsew.
    for (int b = 0; b < NBYTES; b++) begin
      if (VL_W'(b >> req_vsew_i) >= req_vl_i) begin
        dest_init[8*b +: 8] = 8'hFF;
      end
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Result write: byte-wise merge of the low SEW bits into element retire_idx
  // --------------------------------------------------------------------------
  always_comb begin
    dest_upd = dest;
    for (int b = 0; b < NBYTES; b++) begin
      if (res_accept && lane_result_en_i && (VL_W'(b >> vsew) == retire_idx)) begin
        dest_upd[8*b +: 8] = lane_result_i[8*(b & ((1 << vsew) - 1)) +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered lane_valid_o / wb_valid_o
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= SEQ_IDLE;
      lane_valid_o <= 1'b0;
      wb_valid_o   <= 1'b0;
      vl           <= '0;
      issue_idx    <= '0;
      retire_idx   <= '0;
      dest         <= '0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (req_valid_i) begin
            dest       <= dest_init;
            vl         <= req_vl_i;
            issue_idx  <= '0;
            retire_idx <= '0;
            if (req_vl_i == '0) begin
              state      <= SEQ_WB;
              wb_valid_o <= 1'b1;
            end else begin
              state        <= SEQ_ISSUE;
              lane_valid_o <= 1'b1;
            end
          end
        end

        SEQ_ISSUE: begin
          dest       <= dest_upd;
          retire_idx <= retire_nxt;
          issue_idx  <= issue_idx + VL_W'(1);
          if (issue_idx == vl - VL_W'(1)) begin
            lane_valid_o <= 1'b0;
            if (all_retired) begin
              state      <= SEQ_WB;
              wb_valid_o <= 1'b1;
            end else begin
              state <= SEQ_DRAIN;
            end
          end
        end

        SEQ_DRAIN: begin
          dest       <= dest_upd;
          retire_idx <= retire_nxt;
          if (all_retired) begin
            state      <= SEQ_WB;
            wb_valid_o <= 1'b1;
          end
        end

        SEQ_WB: begin
          if (wb_ready_i) begin
            state      <= SEQ_IDLE;
            wb_valid_o <= 1'b0;
          end
        end

        default: begin
          state        <= SEQ_IDLE;
          lane_valid_o <= 1'b0;
          wb_valid_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vpu_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpu_lane_sequencer
// Description : Self-checking bench for vpu_lane_sequencer. A lane model
//               answers issued elements (VALU same cycle, VMUL two cycles
//               later); expected writebacks are computed from the request
//               with plain element arithmetic and queued; a monitor compares
//               issue operands and writebacks as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_lane_sequencer;
  import vpu_pkg::*;

  localparam int VLEN     = 256;
  localparam int MAX_ELEM = VLEN / 8;
  localparam int VL_W     = $clog2(MAX_ELEM) + 1;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_valid_i;
  logic                req_ready_o;
  VPU_FU_t             req_fu_i;
  VPU_MODE_t           req_mode_i;
  VSEW_e               req_vsew_i;
  VXRM_e               req_vxrm_i;
  logic [VL_W-1:0]     req_vl_i;
  logic [VLEN-1:0]     req_vs1_i, req_vs2_i, req_vs3_i;
  logic [MAX_ELEM-1:0] req_v0_i;
  logic                lane_valid_o;
  VPU_FU_t             lane_fu_o;
  VPU_MODE_t           lane_mode_o;
  VSEW_e               lane_vsew_o;
  VXRM_e               lane_vxrm_o;
  logic [63:0]         lane_op1_o, lane_op2_o, lane_op3_o;
  logic                lane_mask_o;
  logic                lane_result_valid_i;
  logic                lane_result_en_i;
  logic [63:0]         lane_result_i;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [VLEN-1:0]     wb_data_o;

  always #5 clk = ~clk;

  vpu_lane_sequencer #(.VLEN(VLEN)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_fu_i            (req_fu_i),
    .req_mode_i          (req_mode_i),
    .req_vsew_i          (req_vsew_i),
    .req_vxrm_i          (req_vxrm_i),
    .req_vl_i            (req_vl_i),
    .req_vs1_i           (req_vs1_i),
    .req_vs2_i           (req_vs2_i),
    .req_vs3_i           (req_vs3_i),
    .req_v0_i            (req_v0_i),
    .lane_valid_o        (lane_valid_o),
    .lane_fu_o           (lane_fu_o),
    .lane_mode_o         (lane_mode_o),
    .lane_vsew_o         (lane_vsew_o),
    .lane_vxrm_o         (lane_vxrm_o),
    .lane_op1_o          (lane_op1_o),
    .lane_op2_o          (lane_op2_o),
    .lane_op3_o          (lane_op3_o),
    .lane_mask_o         (lane_mask_o),
    .lane_result_valid_i (lane_result_valid_i),
    .lane_result_en_i    (lane_result_en_i),
    .lane_result_i       (lane_result_i),
    .wb_valid_o          (wb_valid_o),
    .wb_ready_i          (wb_ready_i),
    .wb_data_o           (wb_data_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cycle;
    logic [VLEN-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          due;
    logic [63:0] r;
    logic        en;
  } lres_t;
  lres_t lq[$];

  // current instruction as seen by the issue monitor
  logic [VLEN-1:0]     cur_vs1, cur_vs2, cur_vs3;
  logic [MAX_ELEM-1:0] cur_v0;
  VPU_FU_t             cur_fu = FU_VALU;
  int                  cur_sew = 8;
  int                  cur_vl = 0;
  int                  issue_cnt = 0;
  bit                  busy = 0;
  bit                  armed = 0;
  bit                  stray = 0;
  int                  ready_mode = 2;

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] sew_mask(input int sewb);
    return (sewb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sewb) - 64'd1);
  endfunction

  function automatic logic [63:0] elem_of(input logic [VLEN-1:0] vec, input int sewb, input int i);
    return 64'(vec >> (i * sewb)) & sew_mask(sewb);
  endfunction

  // Expected destination register from the instruction's element rules.
  function automatic logic [VLEN-1:0] ref_wb(input VPU_FU_t fu, input int sewb, input int vl,
                                             input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                             input logic [VLEN-1:0] c, input logic [MAX_ELEM-1:0] m);
    logic [VLEN-1:0] r;
    logic [63:0]     x, y, z, v;
    r = '0;
    for (int i = 0; i < VLEN / sewb; i++) begin
      x = elem_of(a, sewb, i);
      y = elem_of(b, sewb, i);
      z = elem_of(c, sewb, i);
      if (i < vl) begin
        if (m[i]) v = ((fu == FU_VMUL) ? (x * y) : (x + y)) & sew_mask(sewb);
        else      v = z;
      end else begin
`ifdef VPU_SEQ_TAIL_AGNOSTIC_EN
        v = sew_mask(sewb);
`else
        v = z;
`endif
      end
      r = r | (VLEN'(v) << (i * sewb));
    end
    return r;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] r;
    for (int i = 0; i < VLEN / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Lane model: answers each issued element with op1+op2 (VALU, same cycle)
  // or op1*op2 (VMUL, two cycles later); bits above SEW carry garbage.
  initial begin
    logic [63:0] r, m, g;
    lane_result_valid_i = 1'b0;
    lane_result_en_i    = 1'b0;
    lane_result_i       = '0;
    forever begin
      @(posedge clk); #1;
      lane_result_valid_i = 1'b0;
      lane_result_en_i    = 1'b0;
      lane_result_i       = {$urandom, $urandom};
      if (lane_valid_o === 1'b1 && !rst_i) begin
        m = sew_mask(8 << int'(lane_vsew_o));
        g = {$urandom, $urandom};
        r = (lane_fu_o == FU_VMUL) ? (lane_op1_o * lane_op2_o) : (lane_op1_o + lane_op2_o);
        r = (r & m) | (g & ~m);
        if (lane_fu_o == FU_VMUL) begin
          lq.push_back('{cyc + 2, r, lane_mask_o});
        end else begin
          lane_result_valid_i = 1'b1;
          lane_result_en_i    = lane_mask_o;
          lane_result_i       = r;
        end
      end
      if (lq.size() > 0 && lq[0].due == cyc) begin
        lane_result_valid_i = 1'b1;
        lane_result_en_i    = lq[0].en;
        lane_result_i       = lq[0].r;
        void'(lq.pop_front());
      end
      if (stray) begin
        lane_result_valid_i = 1'b1;
        lane_result_en_i    = 1'b1;
        lane_result_i       = '1;
      end
    end
  end

  // Writeback acceptance pattern.
  initial begin
    wb_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       wb_ready_i = ($urandom_range(0, 2) != 0);
        1:       wb_ready_i = 1'b0;
        default: wb_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: issue operands, ready, writeback latency/data.
  initial begin
    bit prev_wbv = 0;
    forever begin
      @(negedge clk);
      if (armed && !rst_i) begin
        check("req_ready", VLEN'(req_ready_o), VLEN'(!busy));
        if (lane_valid_o) begin
          if (issue_cnt >= cur_vl) begin
            total++; bad++;
            $display("FAIL issue_extra actual=%0d required<%0d", issue_cnt, cur_vl);
          end else begin
            check("issue_op1", VLEN'(lane_op1_o), VLEN'(elem_of(cur_vs1, cur_sew, issue_cnt)));
            check("issue_op2", VLEN'(lane_op2_o), VLEN'(elem_of(cur_vs2, cur_sew, issue_cnt)));
            check("issue_op3", VLEN'(lane_op3_o), VLEN'(elem_of(cur_vs3, cur_sew, issue_cnt)));
            check("issue_mask", VLEN'(lane_mask_o), VLEN'(cur_v0[issue_cnt]));
            check("issue_fu", VLEN'(lane_fu_o), VLEN'(cur_fu));
          end
          issue_cnt++;
        end
        if (wb_valid_o) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL wb_unexpected actual=valid required=idle");
          end else begin
            if (!prev_wbv) begin
              check("wb_latency", VLEN'(cyc), VLEN'(sb[0].cycle));
              check("issue_count", VLEN'(issue_cnt), VLEN'(cur_vl));
            end
            check("wb_data", wb_data_o, sb[0].data);
            if (wb_ready_i) begin
              void'(sb.pop_front());
              busy = 0;
            end
          end
        end
        prev_wbv = wb_valid_o;
      end else begin
        prev_wbv = 0;
      end
    end
  end

  task automatic issue(input VPU_FU_t fu, input VSEW_e sew, input int vl,
                       input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                       input logic [VLEN-1:0] c, input logic [MAX_ELEM-1:0] m);
    int   n;
    exp_t e;
    int   sewb;
    n    = 0;
    sewb = 8 << int'(sew);
    @(posedge clk); #1;
    while (!req_ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready_o) begin
      total++; bad++;
      $display("FAIL req_timeout actual=busy required=ready");
      return;
    end
    req_valid_i = 1'b1;
    req_fu_i    = fu;
    req_mode_i  = VPU_MODE_t'($urandom);
    req_vsew_i  = sew;
    req_vxrm_i  = VXRM_e'($urandom_range(0, 3));
    req_vl_i    = VL_W'(vl);
    req_vs1_i   = a;
    req_vs2_i   = b;
    req_vs3_i   = c;
    req_v0_i    = m;
    cur_vs1 = a; cur_vs2 = b; cur_vs3 = c; cur_v0 = m;
    cur_fu  = fu; cur_sew = sewb; cur_vl = vl; issue_cnt = 0;
    e.cycle = cyc + ((vl == 0) ? 1 : ((fu == FU_VMUL) ? vl + 3 : vl + 1));
    e.data  = ref_wb(fu, sewb, vl, a, b, c, m);
    sb.push_back(e);
    @(posedge clk);
    busy = 1;
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || busy) begin
      total++; bad++;
      $display("FAIL wb_timeout actual=pending required=done");
      sb.delete();
      busy = 0;
    end
  endtask

  initial begin
    logic [VLEN-1:0] a, b, c;
    VSEW_e           sew;
    VPU_FU_t         fu;
    int              sewb, vl, n;

    req_valid_i = 1'b0;
    req_fu_i    = FU_VALU;
    req_mode_i  = '0;
    req_vsew_i  = SEW8;
    req_vxrm_i  = VXRM_RNU;
    req_vl_i    = '0;
    req_vs1_i   = '0;
    req_vs2_i   = '0;
    req_vs3_i   = '0;
    req_v0_i    = '0;

    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lane_valid", VLEN'(lane_valid_o), '0);
    check("rst_wb_valid", VLEN'(wb_valid_o), '0);
    check("rst_wb_data", wb_data_o, '0);
    check("rst_req_ready", VLEN'(req_ready_o), VLEN'(1));
    rst_i = 1'b0;
    armed = 1;

    // VALU SEW32 vl=4: vs1 = 1..4, vs2 = 10..40
    a = '0; b = '0;
    for (int i = 0; i < 4; i++) begin
      a[32*i +: 32] = 32'(i + 1);
      b[32*i +: 32] = 32'(10 * (i + 1));
    end
    issue(FU_VALU, SEW32, 4, a, b, rand_vec(), '1);
    wait_idle();

    // VMUL SEW16 vl=3
    issue(FU_VMUL, SEW16, 3, rand_vec(), rand_vec(), rand_vec(), '1);
    wait_idle();

    // SEW32 vl=4 with element 1 masked off; old vd element 1 = DEADBEEF
    c = rand_vec();
    c[63:32] = 32'hDEADBEEF;
    issue(FU_VALU, SEW32, 4, rand_vec(), rand_vec(), c, MAX_ELEM'(4'b1101));
    wait_idle();

    // vl=0: straight to writeback
    issue(FU_VALU, SEW8, 0, rand_vec(), rand_vec(), rand_vec(), '1);
    wait_idle();

    // Writeback back-pressure for three cycles
    ready_mode = 1;
    issue(FU_VALU, SEW16, 5, rand_vec(), rand_vec(), rand_vec(), '1);
    n = 0;
    while (!wb_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wb_valid_o) begin
      total++; bad++;
      $display("FAIL stall_wb_timeout actual=0 required=1");
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    ready_mode = 2;
    issue(FU_VMUL, SEW64, 2, rand_vec(), rand_vec(), rand_vec(), '1);
    wait_idle();

    // Reset while element 2 of 8 is on the lane
    issue(FU_VALU, SEW8, 8, rand_vec(), rand_vec(), rand_vec(), '1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_i = 1'b1;
    @(posedge clk); #2;
    rst_i = 1'b0;
    sb.delete();
    lq.delete();
    busy = 0;
    cur_vl = 0;
    issue_cnt = 0;
    check("mid_rst_lane_valid", VLEN'(lane_valid_o), '0);
    check("mid_rst_req_ready", VLEN'(req_ready_o), VLEN'(1));
    stray = 1;
    @(posedge clk); #2;
    stray = 0;
    @(posedge clk); #2;
    check("stray_wb_valid", VLEN'(wb_valid_o), '0);
    check("stray_lane_valid", VLEN'(lane_valid_o), '0);
    issue(FU_VMUL, SEW32, 8, rand_vec(), rand_vec(), rand_vec(), '1);
    wait_idle();

    // Randomized instructions with random back-pressure
    ready_mode = 0;
    for (int t = 0; t < 40; t++) begin
      sew  = VSEW_e'($urandom_range(0, 3));
      sewb = 8 << int'(sew);
      fu   = ($urandom_range(0, 1) == 0) ? FU_VALU : FU_VMUL;
      vl   = $urandom_range(0, VLEN / sewb);
      issue(fu, sew, vl, rand_vec(), rand_vec(), rand_vec(),
            ($urandom_range(0, 1) == 0) ? '1 : MAX_ELEM'($urandom));
    end
    wait_idle();
    ready_mode = 2;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vpu_lane_sequencer.md
Name: vpu_lane_sequencer

Overview:
- Issue/collect front end for one VPU lane.
- Accepts one whole-register vector instruction, then issues its elements to the lane one per cycle (fu, mode, 64-bit operands, mask bit).
- Collects the lane's in-order result stream into a destination buffer and presents the completed VLEN-bit register for writeback to the VRF.
- Sits between VPU dispatch/VRF read and the lane.

Parameters:
- VLEN, 256, vector register width in bits (multiple of 64).
- MAX_ELEM, VLEN/8, element count at SEW=8.
- VL_W, $clog2(MAX_ELEM)+1, width of vl.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  1  instruction request valid
- req_ready_o  out  1  sequencer can accept a request (state IDLE)
- req_fu_i  in  VPU_FU_t  target functional unit
- req_mode_i  in  VPU_MODE_t  alu/mul control
- req_vsew_i  in  VSEW_e  element width
- req_vxrm_i  in  VXRM_e  rounding mode
- req_vl_i  in  VL_W  active element count
- req_vs1_i, req_vs2_i, req_vs3_i  in  VLEN  source registers (vs3 = old vd / accumulator)
- req_v0_i  in  MAX_ELEM  mask bits, one per element; all-ones when unmasked
- lane_valid_o  out  1  element issue valid
- lane_fu_o  out  VPU_FU_t  held constant for the whole instruction
- lane_mode_o, lane_vsew_o, lane_vxrm_o  out  held from request
- lane_op1_o, lane_op2_o, lane_op3_o  out  64  current element, zero-extended
- lane_mask_o  out  1  v0 bit of current element
- lane_result_valid_i  in  1  result returned
- lane_result_en_i  in  1  result must be written
- lane_result_i  in  64  result; low SEW bits used
- wb_valid_o  out  1  destination register ready
- wb_ready_i  in  1  VRF accepts writeback
- wb_data_o  out  VLEN  destination register value

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset values: state IDLE, lane_valid_o=0, wb_valid_o=0, wb_data_o=0, counters=0. req_ready_o=1 after reset.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all request fields and copy vs3 into the dest buffer.
  - If vl==0, go to WB; otherwise go to ISSUE.
- ISSUE:
  - lane_valid_o=1 every cycle.
  - Operands are element issue_idx of vs1/vs2/vs3 at SEW width, zero-extended to 64. lane_mask_o = v0[issue_idx].
  - issue_idx increments each cycle.
  - After issuing element vl-1, go to DRAIN; if all results are already retired, go straight to WB.
- Results:
  - Every lane_result_valid_i while retire_idx<vl increments retire_idx.
  - If lane_result_en_i=1, write the low SEW bits of lane_result_i into dest element retire_idx; otherwise the element is unchanged (keeps vs3).
  - lane_result_valid_i with nothing outstanding is ignored.
  - VALU returns its result in the issue cycle. VMUL returns it two cycles after issue; issue and retire overlap.
- DRAIN: lane_valid_o=0. Go to WB the cycle after retire_idx reaches vl.
- WB:
  - wb_valid_o=1 and wb_data_o=dest buffer, both stable until wb_ready_i.
  - On the handshake, go to IDLE; wb_valid_o drops the next cycle.
- Latency: request accepted in cycle 0.
  - VALU: wb_valid_o rises in cycle vl+1.
  - VMUL: wb_valid_o rises in cycle vl+3.
- Tail elements (index >= vl) keep vs3.
- Only one instruction is in flight; no new request is accepted until writeback completes.
- Reset in any state returns to IDLE next cycle and drops lane_valid_o/wb_valid_o. Late lane results are ignored.
- Element index arithmetic: SEW8 index*8, SEW16 *16, SEW32 *32, SEW64 *64. vl is trusted to be <= VLEN/SEW.

Optional Feature:
- Macro: VPU_SEQ_TAIL_AGNOSTIC_EN.
- Defined: tail elements (index >= vl) of wb_data_o are written all-ones. Masked-off elements (result_en=0) still keep vs3.
- Undefined: tail undisturbed (keeps vs3).

Decomposition:
- vpu_pkg already holds VPU_FU_t, VPU_MODE_t, VSEW_e, VXRM_e.
- Add to vpu_pkg: VPU_SEQ_STATE_e (IDLE, ISSUE, DRAIN, WB) and a function giving SEW in bits from VSEW_e.
- One sub-module: vpu_elem_select, a combinational SEW-indexed extract of one element from a VLEN vector, zero-extended to 64. Instantiated three times.

Test Plan:
- VALU, SEW32, vl=4, vs1 elems 1..4, vs2 elems 10..40, lane models add: lane_valid_o high cycles 1-4; wb_data_o low 128 bits = {44,33,22,11}, upper bits = vs3; wb_valid_o in cycle 5.
- VMUL, SEW16, vl=3, 2-cycle lane model: issue cycles 1-3, results cycles 3-5; wb_valid_o in cycle 6; lane_fu_o=VMUL throughout.
- SEW32, vl=4, v0=4'b1101, lane returns result_en=0 for element 1: element 1 = vs3 elem 1 (0xDEADBEEF); others are the lane results.
- vl=0: no lane_valid_o; wb_valid_o in cycle 1 with wb_data_o = vs3. With macro defined, wb_data_o = all-ones.
- wb_ready_i low for 3 cycles: wb_data_o stable, req_ready_o=0; a new request is accepted only after the handshake.
- rst_i asserted mid-ISSUE (element 2 of 8): next cycle lane_valid_o=0, req_ready_o=1; a stray result_valid afterwards is ignored.
